// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing, one-cycle instruction memory interface and 2-entry decode queue
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} cnt_t;
  cnt_t        cnt;
  logic [15:0] pc;
  logic [15:0] fl_pc;
  logic [15:0] e1_instr;
  logic [15:0] e1_pc;
  logic        in_flight;
  logic        push;
  logic        pop;
  logic [2:0]  occ;
  assign imem_addr   = pc;
  assign instr_valid = cnt != EMPTY;
  assign push        = in_flight;
  assign pop         = instr_valid & decode_ready;
  // queued + outstanding - leaving must leave room for the response of a new issue
  assign occ         = 3'(cnt) + 3'(in_flight) - 3'(pop);
  assign imem_en     = reset & ~halt & ~redirect_valid & (occ < 3'd2);
  // PC, in-flight tag and queue; instr/instr_pc are the queue head so they hold when empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      in_flight <= 1'b0;
      fl_pc     <= 16'h0000;
      cnt       <= EMPTY;
      instr     <= 16'h0000;
      instr_pc  <= 16'h0000;
      e1_instr  <= 16'h0000;
      e1_pc     <= 16'h0000;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      in_flight <= 1'b0;
      cnt       <= EMPTY;
    end else begin
      in_flight <= imem_en;
      if (imem_en) begin
        fl_pc <= pc;
        pc    <= pc + 16'd2;
      end
      if (push && (cnt == EMPTY || (cnt == ONE && pop))) begin
        instr    <= imem_rdata;
        instr_pc <= fl_pc;
      end else if (pop && cnt == FULL) begin
        instr    <= e1_instr;
        instr_pc <= e1_pc;
      end
      if (push && ((cnt == ONE && !pop) || cnt == FULL)) begin
        e1_instr <= imem_rdata;
        e1_pc    <= fl_pc;
      end
      cnt <= (push && !pop) ? (cnt == EMPTY ? ONE : FULL) :
             (pop && !push) ? (cnt == FULL ? ONE : EMPTY) : cnt;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch stream, stall, redirect, wrap, halt and async reset
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_pc;
  logic [15:0] held;
  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .decode_ready(decode_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );
  always #5 clk = ~clk;
  // memory: one-cycle read latency, garbage when not requested
  always @(posedge clk) imem_rdata <= imem_en ? (imem_addr ^ 16'hA5A5) : 16'hDEAD;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // advance one cycle; any pop happening at the coming edge must be the next expected instruction
  task automatic tick();
    #1;
    if (instr_valid && decode_ready && reset && !redirect_valid) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_instr", instr, exp_pc ^ 16'hA5A5);
      exp_pc = exp_pc + 16'd2;
    end
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0; decode_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    exp_pc = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_valid", 16'(instr_valid), 16'h0);
    check("rst_en", 16'(imem_en), 16'h0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_addr", imem_addr, 16'h0000);
    reset = 1'b1; decode_ready = 1'b1;
    #1 check("first_en", 16'(imem_en), 16'h1);
    tick();
    check("lat_valid0", 16'(instr_valid), 16'h0);
    tick();
    check("lat_valid", 16'(instr_valid), 16'h1);
    check("first_pc", instr_pc, 16'h0000);
    check("first_instr", instr, 16'hA5A5);
    tick();
    check("second_pc", instr_pc, 16'h0002);
    tick();
    check("third_pc", instr_pc, 16'h0004);
    decode_ready = 1'b0;
    #1 check("stall_en0", 16'(imem_en), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) check("stall_en", 16'(imem_en), 16'h0);
    end
    check("stall_head", instr_pc, 16'h0004);
    decode_ready = 1'b1;
    #1 check("resume_en", 16'(imem_en), 16'h1);
    repeat (3) tick();
    check("resume_pc", instr_pc, 16'h000A);
    decode_ready = 1'b0;
    repeat (2) tick();
    check("full_head", instr_pc, 16'h000A);
    decode_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1 check("redir_en", 16'(imem_en), 16'h0);
    tick();
    redirect_valid = 1'b0; exp_pc = 16'h0100;
    check("redir_flush", 16'(instr_valid), 16'h0);
    check("redir_addr", imem_addr, 16'h0100);
    tick();
    check("redir_gap", 16'(instr_valid), 16'h0);
    tick();
    check("redir_valid", 16'(instr_valid), 16'h1);
    check("redir_pc", instr_pc, 16'h0100);
    tick();
    check("redir_next", instr_pc, 16'h0102);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0; exp_pc = 16'hFFFE;
    repeat (2) tick();
    check("wrap_pc0", instr_pc, 16'hFFFE);
    check("wrap_instr0", instr, 16'h5A5B);
    tick();
    check("wrap_pc1", instr_pc, 16'h0000);
    tick();
    halt = 1'b1;
    held = imem_addr;
    #1 check("halt_en", 16'(imem_en), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_addr", imem_addr, held);
      check("halt_en_hold", 16'(imem_en), 16'h0);
    end
    check("halt_empty", 16'(instr_valid), 16'h0);
    check("halt_seq", exp_pc, held);
    halt = 1'b0;
    #1 check("unhalt_en", 16'(imem_en), 16'h1);
    check("unhalt_addr", imem_addr, held);
    repeat (2) tick();
    check("unhalt_pc", instr_pc, held);
    decode_ready = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1 check("async_valid", 16'(instr_valid), 16'h0);
    check("async_en", 16'(imem_en), 16'h0);
    check("async_pc", instr_pc, 16'h0000);
    check("async_addr", imem_addr, 16'h0000);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 Port: imem_en  output  1  instruction-memory read request this cycle.
REQ-005 Port: imem_addr  output  16  byte address of requested instruction (current PC).
REQ-006 Port: imem_rdata  input  16  read data, valid exactly one cycle after the cycle imem_en was high.
REQ-007 Port: instr  output  16  instruction at head of output queue.
REQ-008 Port: instr_pc  output  16  address of instr.
REQ-009 Port: instr_valid  output  1  instr/instr_pc valid.
REQ-010 Port: decode_ready  input  1  downstream accepts head when high with instr_valid.
REQ-011 Port: redirect_valid  input  1  branch/jump/call/return redirect request.
REQ-012 Port: redirect_pc  input  16  redirect target address.
REQ-013 Port: halt  input  1  suppress new fetches while high.

Function
REQ-014 The block SHALL hold a 16-bit PC register; imem_addr SHALL equal PC combinationally.
REQ-015 On each issue (imem_en=1 at a clock edge), PC SHALL advance by 2, wrapping 16'hFFFE -> 16'h0000 with no carry out.
REQ-016 The block SHALL hold a 1-bit in_flight flag, set to the value of imem_en at each edge.
REQ-017 The block SHALL hold a 2-entry FIFO of {instr, pc}; head drives instr/instr_pc; instr_valid = FIFO not empty.
REQ-018 FIFO occupancy SHALL be tracked as state EMPTY, ONE or FULL; transitions by push (in_flight response captured) and pop (instr_valid && decode_ready): push only -> up one, pop only -> down one, both or neither -> unchanged.
REQ-019 A pop SHALL occur only while instr_valid=1; push and pop in the same cycle SHALL both take effect, preserving order.
REQ-020 imem_en SHALL be 1 iff reset=1, halt=0, redirect_valid=0, and (count + in_flight - pop) < 2; this is combinational from decode_ready.
REQ-021 With decode_ready held high and no halt/redirect, the block SHALL issue every cycle and deliver one instruction per cycle with consecutive instr_pc values.
REQ-022 Issue-to-valid latency SHALL be 2 cycles: address issued in cycle t, captured at end of t+1, instr_valid in t+2.
REQ-023 The pc stored with each entry SHALL be the imem_addr of the issue that produced it (registered alongside in_flight).
REQ-024 When redirect_valid=1 at an edge: PC <= redirect_pc, FIFO -> EMPTY, in_flight <= 0, any response arriving that cycle discarded, no issue that cycle.
REQ-025 redirect_valid SHALL take priority over push, pop, halt and issue in the same cycle.
REQ-026 While halt=1: no issue, PC holds, the in-flight response SHALL still be captured, FIFO drains normally.
REQ-027 No instruction SHALL be lost, duplicated or reordered under any decode_ready pattern.
REQ-028 When instr_valid=0, instr and instr_pc SHALL hold their last values.

Reset
REQ-029 reset=0 SHALL asynchronously set PC=RESET_PC, in_flight=0, FIFO EMPTY, instr=16'h0000, instr_pc=16'h0000, instr_valid=0, imem_en=0.
REQ-030 imem_rdata SHALL be ignored in the first cycle after reset release; the first issue SHALL occur in that cycle at RESET_PC.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and queued instructions.

Verification
REQ-032 Reset release, decode_ready=1, mem[a]=a^16'hA5A5 -> instr_valid first high 2 cycles after release with instr_pc=0000, instr=A5A5; then 0002, 0004 every cycle.
REQ-033 decode_ready=0 for 5 cycles mid-stream -> FIFO FULL, imem_en low while full, on release the sequence resumes with no gap in instr_pc and no duplicate.
REQ-034 redirect_valid=1, redirect_pc=16'h0100 while FIFO FULL -> instr_valid=0 next cycle; next valid instr_pc=0100 exactly 3 cycles after redirect, followed by 0102.
REQ-035 Redirect to 16'hFFFE -> instr_pc FFFE then 0000.
REQ-036 halt=1 for 4 cycles with decode_ready=1 -> imem_en=0 same cycle, in-flight instr delivered, FIFO empties, PC unchanged; on halt=0 fetch resumes at held PC.
REQ-037 reset driven low between clock edges with FIFO FULL -> instr_valid=0 and imem_en=0 immediately, without a clock edge.
